// File: rtl/image_ram_write_arbiter.sv
// Round-robin arbiter sharing the image RAM write port between NUM_LANES PE result streams.
// Optional feature macro: IMAGE_RAM_ARB_BOUNDS_CHECK_EN drops out-of-range entries at push and flags them.
module image_ram_write_arbiter #(
    parameter int NUM_LANES    = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int NO_OF_PIXELS = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_LANES-1:0]          lane_valid,
    output logic [NUM_LANES-1:0]          lane_ready,
    input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_val,
    input  logic [NUM_LANES-1:0]          lane_last,
    input  logic                          ir_enable,
    output logic                          ir_kick,
    output logic                          ir_done,
    output logic [ADDR_W-1:0]             ir_addr,
    output logic [DATA_W-1:0]             ir_val,
    output logic                          busy,
    output logic                          err_oob
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LANE_W  = $clog2(NUM_LANES);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    if (NUM_LANES < 2 || NUM_LANES > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        64'(NO_OF_PIXELS) > (64'd1 << ADDR_W)) begin : g_param_check
        $error("image_ram_write_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_KICK, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_LANES-1:0]   last_seen_reg, last_seen_next;
    logic [LANE_W-1:0]      rr_ptr_reg;
    logic [NUM_LANES-1:0]   full, empty, accept, drop, push, pop;
    logic [ENTRY_W-1:0]     head [NUM_LANES];
    logic                   win_found, issue;
    logic [LANE_W-1:0]      win_idx;

`ifdef IMAGE_RAM_ARB_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] PIXEL_LIMIT = (ADDR_W + 1)'(NO_OF_PIXELS);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
            logic [PTR_W:0]     count_reg;
            logic [ADDR_W-1:0]  addr;

            assign addr           = lane_addr[gi*ADDR_W +: ADDR_W];
            assign full[gi]       = (count_reg == FULL_COUNT);
            assign empty[gi]      = (count_reg == '0);
            assign lane_ready[gi] = (state_reg == ST_RUN) && !full[gi];
            assign accept[gi]     = lane_valid[gi] && lane_ready[gi];
`ifdef IMAGE_RAM_ARB_BOUNDS_CHECK_EN
            assign drop[gi]       = accept[gi] && ({1'b0, addr} >= PIXEL_LIMIT);
`else
            assign drop[gi]       = 1'b0;
`endif
            assign push[gi]       = accept[gi] && !drop[gi];
            assign pop[gi]        = issue && (win_idx == LANE_W'(gi));
            assign head[gi]       = mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= {addr, lane_val[gi*DATA_W +: DATA_W]};
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // First non-empty lane at or after the round-robin pointer, wrapping.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            j = int'(rr_ptr_reg) + k;
            if (j >= NUM_LANES) j = j - NUM_LANES;
            if (!win_found && !empty[LANE_W'(j)]) begin
                win_found = 1'b1;
                win_idx   = LANE_W'(j);
            end
        end
    end

    assign issue = ((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && ir_enable && win_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
            ir_addr    <= '1;
            ir_val     <= '0;
        end else if (issue) begin
            rr_ptr_reg <= (win_idx == LANE_W'(NUM_LANES - 1)) ? '0 : win_idx + 1'b1;
            ir_addr    <= head[win_idx][ENTRY_W-1:DATA_W];
            ir_val     <= head[win_idx][DATA_W-1:0];
        end else begin
            ir_addr    <= '1;
            ir_val     <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            last_seen_reg <= '0;
        end else begin
            state_reg     <= state_next;
            last_seen_reg <= last_seen_next;
        end
    end

    // DONE waits for the output register to return to the sentinel so the last write is not cut off.
    always_comb begin
        state_next     = state_reg;
        last_seen_next = last_seen_reg;
        case (state_reg)
            ST_IDLE: begin
                last_seen_next = '0;
                if (start) state_next = ST_KICK;
            end
            ST_KICK:  state_next = ST_RUN;
            ST_RUN: begin
                last_seen_next = last_seen_reg | lane_last;
                if (&last_seen_reg) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((&empty) && (ir_addr == '1)) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign ir_kick = (state_reg == ST_KICK);
    assign ir_done = (state_reg == ST_DONE);
    assign busy    = (state_reg != ST_IDLE);

`ifdef IMAGE_RAM_ARB_BOUNDS_CHECK_EN
    logic [15:0] oob_count;
    logic        err_oob_reg;
    logic [16:0] oob_sum;

    always_comb begin
        oob_sum = {1'b0, oob_count};
        for (int k = 0; k < NUM_LANES; k++) begin
            oob_sum = oob_sum + {16'b0, drop[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_count   <= '0;
            err_oob_reg <= 1'b0;
        end else begin
            if (|drop) err_oob_reg <= 1'b1;
            oob_count <= oob_sum[16] ? 16'hFFFF : oob_sum[15:0];
        end
    end

    assign err_oob = err_oob_reg;
`else
    assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_image_ram_write_arbiter.sv
// Scoreboard bench for image_ram_write_arbiter: per-lane expected queues filled on handshake, drained by a monitor.
module tb_image_ram_write_arbiter;
    localparam int NL   = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int NPIX = 4096;

    logic             clk = 1'b0;
    logic             reset, start, ir_enable;
    logic [NL-1:0]    lane_valid, lane_ready, lane_last;
    logic [NL*AW-1:0] lane_addr;
    logic [NL*DW-1:0] lane_val;
    logic             ir_kick, ir_done, busy, err_oob;
    logic [AW-1:0]    ir_addr;
    logic [DW-1:0]    ir_val;

    image_ram_write_arbiter dut (
        .clk(clk), .reset(reset), .start(start),
        .lane_valid(lane_valid), .lane_ready(lane_ready),
        .lane_addr(lane_addr), .lane_val(lane_val), .lane_last(lane_last),
        .ir_enable(ir_enable), .ir_kick(ir_kick), .ir_done(ir_done),
        .ir_addr(ir_addr), .ir_val(ir_val), .busy(busy), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int done_cnt = 0, issue_cnt = 0, push_cnt = 0;
    int last_lane = NL - 1;
    int seq = 0;
    logic en_prev = 1'b1;
    logic [AW+DW-1:0] exp_q [NL][$];
    int issue_lane_q [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Lane number is encoded in address bits [11:10] so the monitor can route an issue to its queue.
    function automatic logic [AW-1:0] mk_addr(int k, int s);
        return AW'(k * 1024 + (s % 1024));
    endfunction

    function automatic int pending();
        int n = 0;
        for (int k = 0; k < NL; k++) n += exp_q[k].size();
        return n;
    endfunction

    always @(negedge clk) begin : monitor
        int lane;
        logic [AW+DW-1:0] e;
        logic [AW-1:0] a;
        if (reset) begin
            for (int k = 0; k < NL; k++) exp_q[k].delete();
            en_prev   = 1'b1;
            last_lane = NL - 1;
        end else begin
            if (ir_done) done_cnt++;
            if (!en_prev) check("sentinel_when_disabled", ir_addr, 32'hFFFF);
            if (ir_addr != 16'hFFFF) begin
                lane = int'(ir_addr >> 10) % NL;
                issue_cnt++;
                issue_lane_q.push_back(lane);
                last_lane = lane;
                if (exp_q[lane].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual_addr=0x%0h required=none_pending", ir_addr);
                end else begin
                    e = exp_q[lane].pop_front();
                    check("issue_addr", ir_addr, e[AW+DW-1:DW]);
                    check("issue_val", ir_val, e[DW-1:0]);
                end
            end
            for (int k = 0; k < NL; k++) begin
                if (lane_valid[k] && lane_ready[k]) begin
                    a = lane_addr[k*AW +: AW];
`ifdef IMAGE_RAM_ARB_BOUNDS_CHECK_EN
                    if (a < NPIX) begin
`else
                    begin
`endif
                        exp_q[k].push_back({a, lane_val[k*DW +: DW]});
                        push_cnt++;
                    end
                end
            end
            en_prev = ir_enable;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lane(int k, logic [AW-1:0] a, logic [DW-1:0] v);
        lane_addr[k*AW +: AW] = a;
        lane_val[k*DW +: DW]  = v;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("kick_after_start", ir_kick, 1);
        check("busy_in_kick", busy, 1);
        check("ready_in_kick", lane_ready, 0);
        tick();
        @(negedge clk);
        check("kick_one_cycle", ir_kick, 0);
        tick();
    endtask

    task automatic finish_frame(int budget);
        int d0 = done_cnt;
        int n = 0;
        lane_valid = '0;
        ir_enable  = 1'b1;
        lane_last  = '1;
        tick();
        lane_last  = '0;
        while (n < budget) begin
            @(negedge clk);
            if (ir_done) break;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
        tick();
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_pulse", done_cnt, d0 + 1);
        check("all_entries_issued", pending(), 0);
        tick();
    endtask

    task automatic basic_frame();
        int i0;
        start_frame();
        i0 = issue_cnt;
        lane_valid[0] = 1'b1;
        drive_lane(0, 16'd5, 8'h11);
        tick();
        finish_frame(50);
        check("basic_issue_count", issue_cnt - i0, 1);
    endtask

    initial begin
        int i0, p0, d0, exp_first;
        reset = 1'b1; start = 1'b0; ir_enable = 1'b1;
        lane_valid = '0; lane_last = '0; lane_addr = '0; lane_val = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_lane_ready", lane_ready, 0);
        check("rst_kick", ir_kick, 0);
        check("rst_done", ir_done, 0);
        check("rst_addr", ir_addr, 32'hFFFF);
        check("rst_val", ir_val, 0);
        check("rst_busy", busy, 0);
        check("rst_err_oob", err_oob, 0);
        tick();

        basic_frame();

        // Fairness: all lanes continuously valid.
        start_frame();
        exp_first = (last_lane + 1) % NL;
        issue_lane_q.delete();
        lane_valid = '1;
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < NL; k++) drive_lane(k, mk_addr(k, seq), 8'($urandom));
            seq++;
            tick();
        end
        finish_frame(100);
        check("fair_issue_count_min", issue_lane_q.size() >= 16, 1);
        for (int i = 0; i < 16 && i < issue_lane_q.size(); i++)
            check($sformatf("fair_order_%0d", i), issue_lane_q[i], (exp_first + i) % NL);

        // Backpressure: RAM not accepting while lane 0 pushes.
        start_frame();
        ir_enable = 1'b0;
        p0 = push_cnt; i0 = issue_cnt;
        lane_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive_lane(0, mk_addr(0, seq), 8'($urandom));
            seq++;
            tick();
        end
        lane_valid = '0;
        @(negedge clk);
        check("bp_pushes_accepted", push_cnt - p0, 4);
        check("bp_lane0_not_ready", lane_ready[0], 0);
        check("bp_no_issue", issue_cnt - i0, 0);
        tick();
        finish_frame(50);
        check("bp_drained", issue_cnt - i0, 4);

        // Drain: lane_last while three entries are buffered.
        start_frame();
        ir_enable = 1'b0;
        i0 = issue_cnt;
        lane_valid[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_lane(1, mk_addr(1, seq), 8'($urandom));
            seq++;
            tick();
        end
        lane_valid = '0;
        lane_last  = '1;
        tick();
        lane_last  = '0;
        tick();
        @(negedge clk);
        check("drain_not_ready", lane_ready, 0);
        check("drain_busy", busy, 1);
        check("drain_buffered", pending(), 3);
        tick();
        finish_frame(50);
        check("drain_issue_count", issue_cnt - i0, 3);

        // Reset mid-frame with two entries buffered.
        start_frame();
        ir_enable = 1'b0;
        lane_valid[2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_lane(2, mk_addr(2, seq), 8'($urandom));
            seq++;
            tick();
        end
        lane_valid = '0;
        d0 = done_cnt; i0 = issue_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_addr", ir_addr, 32'hFFFF);
        check("midrst_busy", busy, 0);
        check("midrst_ready", lane_ready, 0);
        tick();
        ir_enable = 1'b1;
        repeat (6) tick();
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_issue", issue_cnt - i0, 0);
        basic_frame();

        // Out-of-range address followed by an in-range one.
        start_frame();
        i0 = issue_cnt;
        lane_valid[0] = 1'b1;
        drive_lane(0, 16'd4096, 8'h44);
        tick();
        drive_lane(0, 16'd10, 8'h55);
        tick();
        finish_frame(50);
`ifdef IMAGE_RAM_ARB_BOUNDS_CHECK_EN
        check("oob_issue_count", issue_cnt - i0, 1);
        check("oob_err_sticky", err_oob, 1);
        check("oob_count", dut.oob_count, 1);
`else
        check("oob_issue_count", issue_cnt - i0, 2);
        check("oob_err_off", err_oob, 0);
`endif

        // Randomized frames.
        for (int f = 0; f < 3; f++) begin
            start_frame();
            p0 = push_cnt; i0 = issue_cnt;
            for (int c = 0; c < 150; c++) begin
                lane_valid = NL'($urandom);
                ir_enable  = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < NL; k++)
                    drive_lane(k, mk_addr(k, $urandom_range(0, 1023)), 8'($urandom));
                tick();
            end
            finish_frame(200);
            check($sformatf("rand_frame%0d_push_eq_issue", f), issue_cnt - i0, push_cnt - p0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
